bullet_pool: RTL and testbench

Parametrised projectile manager for the tank game. It generalises the engine's fixed per-player bullet bank to NUM_PLAYERS independent banks of MAX_BULLETS slots each, and owns spawn, per-frame motion, boundary retirement, hit removal and fire cooldown. It sits between player/AI control and the renderer, and publishes one packed 32-bit state word per slot in the engine's RAM-word format.

---
 rtl/tank_pkg.sv | 36 +++
 rtl/bullet_slot.sv | 92 +++++++++
 rtl/bullet_pool.sv | 126 ++++++++++++
 tb/tb_bullet_pool.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// Shared definitions for the tank game: direction encoding, the packed RAM-word
// layout used by the renderer, and a helper that builds that word.
package tank_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam int COORD_W    = 10;
    localparam int ACTIVE_BIT = 28;
    localparam int X_LSB      = 18;
    localparam int Y_LSB      = 8;
    localparam int DIR_LSB    = 6;
    localparam int OWNER_LSB  = 3;

    function automatic logic [31:0] pack_word(
        input logic               active,
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y,
        input dir_t               dir,
        input logic [2:0]         owner
    );
        logic [31:0] w;
        w = '0;
        w[ACTIVE_BIT]                 = active;
        w[X_LSB +: COORD_W]           = x;
        w[Y_LSB +: COORD_W]           = y;
        w[DIR_LSB +: 2]               = dir;
        w[OWNER_LSB +: 3]             = owner;
        return w;
    endfunction

endpackage

// File: rtl/bullet_slot.sv
// One projectile slot: spawn load, per-tick motion with boundary retirement,
// and kill. Load wins over kill (a kill aimed at a free slot is a no-op anyway).
module bullet_slot
    import tank_pkg::*;
#(
    parameter int SPEED = 4,
    parameter int X_MAX = 639,
    parameter int Y_MAX = 479
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               load,
    input  logic [COORD_W-1:0] load_x,
    input  logic [COORD_W-1:0] load_y,
    input  dir_t               load_dir,
    input  logic [2:0]         load_owner,
    input  logic               kill,
    output logic               active,
    output logic [31:0]        word
);

    localparam logic [10:0] SPEED_W = 11'(SPEED);
    localparam logic [10:0] X_MAX_W = 11'(X_MAX);
    localparam logic [10:0] Y_MAX_W = 11'(Y_MAX);

    logic               active_reg;
    logic [COORD_W-1:0] x_reg, y_reg;
    dir_t               dir_reg;
    logic [2:0]         owner_reg;

    logic [10:0]        x_ext, y_ext;
    logic [COORD_W-1:0] x_next, y_next;
    logic               retire;

    assign x_ext = {1'b0, x_reg};
    assign y_ext = {1'b0, y_reg};

    // 11-bit arithmetic so the down/right sums cannot wrap before the bound test.
    always_comb begin
        x_next = x_reg;
        y_next = y_reg;
        retire = 1'b0;
        case (dir_reg)
            DIR_UP: begin
                if (y_ext < SPEED_W) retire = 1'b1;
                else y_next = 10'(y_ext - SPEED_W);
            end
            DIR_DOWN: begin
                if (y_ext + SPEED_W > Y_MAX_W) retire = 1'b1;
                else y_next = 10'(y_ext + SPEED_W);
            end
            DIR_LEFT: begin
                if (x_ext < SPEED_W) retire = 1'b1;
                else x_next = 10'(x_ext - SPEED_W);
            end
            default: begin
                if (x_ext + SPEED_W > X_MAX_W) retire = 1'b1;
                else x_next = 10'(x_ext + SPEED_W);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_reg <= 1'b0;
            x_reg      <= '0;
            y_reg      <= '0;
            dir_reg    <= DIR_UP;
            owner_reg  <= '0;
        end else if (load) begin
            active_reg <= 1'b1;
            x_reg      <= load_x;
            y_reg      <= load_y;
            dir_reg    <= load_dir;
            owner_reg  <= load_owner;
        end else if (kill) begin
            active_reg <= 1'b0;
        end else if (tick && active_reg) begin
            if (retire) begin
                active_reg <= 1'b0;
            end else begin
                x_reg <= x_next;
                y_reg <= y_next;
            end
        end
    end

    assign active = active_reg;
    assign word   = pack_word(active_reg, x_reg, y_reg, dir_reg, owner_reg);

endmodule

// File: rtl/bullet_pool.sv
// Per-player projectile banks: fire edge detect, lowest-free-slot selection,
// cooldown counters and registered live-bullet counts around an array of slots.
module bullet_pool
    import tank_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int MAX_BULLETS = 8,
    parameter int SPEED       = 4,
    parameter int COOLDOWN    = 16,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    localparam int NS = NUM_PLAYERS * MAX_BULLETS,
    localparam int KW = (NS > 1) ? $clog2(NS) : 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 tick,
    input  logic [NUM_PLAYERS-1:0]               fire,
    input  logic [NUM_PLAYERS-1:0][COORD_W-1:0]  fire_x,
    input  logic [NUM_PLAYERS-1:0][COORD_W-1:0]  fire_y,
    input  logic [NUM_PLAYERS-1:0][1:0]          fire_dir,
    input  logic                                 kill_valid,
    input  logic [KW-1:0]                        kill_idx,
    output logic [NUM_PLAYERS-1:0]               fire_ack,
    output logic [NS-1:0][31:0]                  bullet_ram_data,
    output logic [NUM_PLAYERS-1:0][4:0]          active_count
);

    localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam int SW = (MAX_BULLETS > 1) ? $clog2(MAX_BULLETS) : 1;

    logic [NUM_PLAYERS-1:0]          fire_prev_reg;
    logic                            primed_reg;
    logic [NUM_PLAYERS-1:0][CW-1:0]  cd_reg;
    logic [NUM_PLAYERS-1:0]          fire_ack_reg;
    logic [NUM_PLAYERS-1:0][4:0]     count_reg;

    logic [NUM_PLAYERS-1:0]          has_free, accept;
    logic [NUM_PLAYERS-1:0][SW-1:0]  free_sel;
    logic [NUM_PLAYERS-1:0][4:0]     count_next;
    logic [NS-1:0]                   slot_load, slot_kill, slot_active;
    logic [31:0]                     slot_word [NS];

    // Descending scan so the lowest-index free slot is the one left selected.
    // primed_reg blocks the first post-reset cycle, so a button held through
    // reset release never counts as a press.
    always_comb begin
        has_free = '0;
        free_sel = '0;
        accept   = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            for (int s = MAX_BULLETS - 1; s >= 0; s--) begin
                if (!slot_active[p*MAX_BULLETS + s]) begin
                    has_free[p] = 1'b1;
                    free_sel[p] = SW'(s);
                end
            end
            accept[p] = primed_reg && fire[p] && !fire_prev_reg[p]
                        && (cd_reg[p] == '0) && has_free[p];
        end
    end

    always_comb begin
        count_next = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            for (int s = 0; s < MAX_BULLETS; s++) begin
                count_next[p] = count_next[p] + 5'(slot_active[p*MAX_BULLETS + s]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fire_prev_reg <= '0;
            primed_reg    <= 1'b0;
            cd_reg        <= '0;
            fire_ack_reg  <= '0;
            count_reg     <= '0;
        end else begin
            fire_prev_reg <= fire;
            primed_reg    <= 1'b1;
            fire_ack_reg  <= accept;
            count_reg     <= count_next;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (accept[p]) cd_reg[p] <= CW'(COOLDOWN);
                else if (tick && cd_reg[p] != '0) cd_reg[p] <= cd_reg[p] - 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NS; gi++) begin : g_slot
            localparam int PLAYER = gi / MAX_BULLETS;
            localparam int SLOT   = gi % MAX_BULLETS;

            assign slot_load[gi] = accept[PLAYER] && (free_sel[PLAYER] == SW'(SLOT));
            assign slot_kill[gi] = kill_valid && (kill_idx == KW'(gi));

            bullet_slot #(
                .SPEED (SPEED),
                .X_MAX (X_MAX),
                .Y_MAX (Y_MAX)
            ) u_slot (
                .clk        (clk),
                .reset      (reset),
                .tick       (tick),
                .load       (slot_load[gi]),
                .load_x     (fire_x[PLAYER]),
                .load_y     (fire_y[PLAYER]),
                .load_dir   (dir_t'(fire_dir[PLAYER])),
                .load_owner (3'(PLAYER)),
                .kill       (slot_kill[gi]),
                .active     (slot_active[gi]),
                .word       (slot_word[gi])
            );
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < NS; i++) bullet_ram_data[i] = slot_word[i];
    end

    assign fire_ack     = fire_ack_reg;
    assign active_count = count_reg;

endmodule

// File: tb/tb_bullet_pool.sv
// Directed bench for bullet_pool with hand-computed expected slot words and counts.
module tb_bullet_pool;

    logic              clk = 1'b0;
    logic              reset, tick, kill_valid;
    logic [1:0]        fire;
    logic [1:0][9:0]   fire_x, fire_y;
    logic [1:0][1:0]   fire_dir;
    logic [3:0]        kill_idx;
    logic [1:0]        fire_ack;
    logic [15:0][31:0] ram;
    logic [1:0][4:0]   cnt;

    int passed = 0;
    int total  = 0;
    int acks;

    bullet_pool dut (
        .clk             (clk),
        .reset           (reset),
        .tick            (tick),
        .fire            (fire),
        .fire_x          (fire_x),
        .fire_y          (fire_y),
        .fire_dir        (fire_dir),
        .kill_valid      (kill_valid),
        .kill_idx        (kill_idx),
        .fire_ack        (fire_ack),
        .bullet_ram_data (ram),
        .active_count    (cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ew(input logic a, input int x, input int y,
                                       input int d, input int o);
        return {3'b000, a, 10'(x), 10'(y), 2'(d), 3'(o), 3'b000};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        $display("check %-16s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; kill_valid = 1'b0; kill_idx = '0;
        fire = '0; fire_x = '0; fire_y = '0; fire_dir = '0;
        cyc(2);
        reset = 1'b0;
        cyc(2);
        chk("rst_word0", ram[0], 32'h0);
        chk("rst_word8", ram[8], 32'h0);
        chk("rst_ack", 32'(fire_ack), 32'h0);
        chk("rst_count", 32'(cnt), 32'h0);

        // First shot, up from (100,200), then one tick.
        fire_x[0] = 10'd100; fire_y[0] = 10'd200; fire_dir[0] = 2'd0; fire[0] = 1'b1;
        cyc(1);
        chk("spawn_word0", ram[0], ew(1, 100, 200, 0, 0));
        chk("spawn_ack", 32'(fire_ack), 32'h1);
        cyc(1);
        chk("ack_pulse", 32'(fire_ack), 32'h0);
        chk("count0_1", 32'(cnt[0]), 32'd1);
        do_tick();
        chk("tick_word0", ram[0], ew(1, 100, 196, 0, 0));

        // Held button: no further acks.
        acks = 1;
        for (int i = 0; i < 38; i++) begin
            cyc(1);
            if (fire_ack[0]) acks++;
        end
        chk("held_acks", 32'(acks), 32'd1);
        fire[0] = 1'b0;
        cyc(1);

        // 15 ticks total: re-press refused.
        for (int i = 0; i < 14; i++) do_tick();
        fire_x[0] = 10'd300; fire_y[0] = 10'd300; fire_dir[0] = 2'd1; fire[0] = 1'b1;
        cyc(1);
        chk("cd15_noack", 32'(fire_ack), 32'h0);
        fire[0] = 1'b0;
        cyc(1);
        do_tick();
        fire[0] = 1'b1;
        cyc(1);
        chk("cd16_ack", 32'(fire_ack), 32'h1);
        chk("cd16_slot1", ram[1], ew(1, 300, 300, 1, 0));
        chk("cd16_word0", ram[0], ew(1, 100, 136, 0, 0));
        fire[0] = 1'b0;
        cyc(1);
        chk("count0_2", 32'(cnt[0]), 32'd2);

        // Kill slot 0 during a tick: killed, not moved; slot 1 moves.
        kill_valid = 1'b1; kill_idx = 4'd0; tick = 1'b1;
        cyc(1);
        kill_valid = 1'b0; tick = 1'b0;
        chk("kill_word0", ram[0], ew(0, 100, 136, 0, 0));
        chk("kill_word1", ram[1], ew(1, 300, 304, 1, 0));
        cyc(1);
        chk("kill_count", 32'(cnt[0]), 32'd1);
        kill_valid = 1'b1; kill_idx = 4'd5;
        cyc(1);
        chk("kill_idle5", ram[5], 32'h0);
        chk("kill_idle1", ram[1], ew(1, 300, 304, 1, 0));
        kill_idx = 4'd1;
        cyc(1);
        kill_valid = 1'b0;
        chk("kill_word1b", ram[1], ew(0, 300, 304, 1, 0));
        cyc(1);
        chk("count0_0", 32'(cnt[0]), 32'd0);

        // Right-edge retirement.
        for (int i = 0; i < 15; i++) do_tick();
        fire_x[0] = 10'd637; fire_y[0] = 10'd50; fire_dir[0] = 2'd3; fire[0] = 1'b1;
        cyc(1);
        fire[0] = 1'b0;
        chk("edge_spawn", ram[0], ew(1, 637, 50, 3, 0));
        cyc(1);
        chk("edge_count1", 32'(cnt[0]), 32'd1);
        do_tick();
        chk("edge_retire", ram[0], ew(0, 637, 50, 3, 0));
        cyc(1);
        chk("edge_count0", 32'(cnt[0]), 32'd0);

        // Fill bank 1: slot i spawned at (639, 10*i) heading left.
        fire_x[1] = 10'd639; fire_dir[1] = 2'd2;
        for (int i = 0; i < 8; i++) begin
            fire_y[1] = 10'(10 * i);
            fire[1] = 1'b1;
            cyc(1);
            fire[1] = 1'b0;
            chk($sformatf("fill_ack%0d", i), 32'(fire_ack), 32'h2);
            chk($sformatf("fill_word%0d", 8 + i), ram[8 + i], ew(1, 639, 10 * i, 2, 1));
            for (int t = 0; t < 16; t++) do_tick();
        end
        fire_y[1] = 10'd99;
        fire[1] = 1'b1;
        cyc(1);
        fire[1] = 1'b0;
        chk("full_noack", 32'(fire_ack), 32'h0);
        for (int i = 0; i < 8; i++)
            chk($sformatf("full_word%0d", 8 + i), ram[8 + i], ew(1, 639 - 64 * (8 - i), 10 * i, 2, 1));
        chk("full_bank0", ram[0], ew(0, 637, 50, 3, 0));
        chk("full_count1", 32'(cnt[1]), 32'd8);

        // Free slot 8, then both players fire in a tick cycle.
        kill_valid = 1'b1; kill_idx = 4'd8;
        cyc(1);
        kill_valid = 1'b0;
        fire_x[0] = 10'd50; fire_y[0] = 10'd60; fire_dir[0] = 2'd3;
        fire_x[1] = 10'd70; fire_y[1] = 10'd80; fire_dir[1] = 2'd0;
        fire = 2'b11; tick = 1'b1;
        cyc(1);
        tick = 1'b0; fire = 2'b00;
        chk("dual_ack", 32'(fire_ack), 32'h3);
        chk("dual_word0", ram[0], ew(1, 50, 60, 3, 0));
        chk("dual_word8", ram[8], ew(1, 70, 80, 0, 1));
        chk("dual_word9", ram[9], ew(1, 187, 10, 2, 1));
        cyc(1);
        chk("dual_count0", 32'(cnt[0]), 32'd1);
        chk("dual_count1", 32'(cnt[1]), 32'd8);

        // Reset mid-run with fire held through release.
        reset = 1'b1; fire[0] = 1'b1;
        cyc(1);
        chk("mrst_word0", ram[0], 32'h0);
        chk("mrst_word9", ram[9], 32'h0);
        reset = 1'b0;
        cyc(1);
        chk("mrst_count", 32'(cnt), 32'h0);
        chk("mrst_noack", 32'(fire_ack), 32'h0);
        cyc(1);
        chk("mrst_noack2", 32'(fire_ack), 32'h0);
        chk("mrst_word0b", ram[0], 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
